ps2_host_transmitter: RTL and testbench
=======================================

Name: ps2_host_transmitter

Overview:
Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard over the shared open-drain PS2_CLK/PS2_DAT lines. It sits beside the scancode receive path on the same PS/2 pins. It performs the inhibit and request-to-send sequence, shifts the frame out on device-generated clocks, and reports completion or error to the controlling logic.

Parameters:
INHIBIT_CYCLES, 5000, CLOCK_50 cycles PS2_CLK is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum CLOCK_50 cycles between consecutive device clock falling edges, and from RTS to the first edge (15 ms).

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous active-high reset
PS2_CLK  inout  1  PS/2 clock; driven only as 0 or Z
PS2_DAT  inout  1  PS/2 data; driven only as 0 or Z
send_cmd  input  1  start request, sampled only in IDLE
cmd_byte  input  8  byte to send, captured when send_cmd is accepted
busy  output  1  high from acceptance until DONE/ERROR returns to IDLE
cmd_sent  output  1  one-cycle pulse on successful completion
tx_error  output  1  one-cycle pulse on timeout or missing ack

Behaviour:
- Pin drive is open drain: each line is 1'b0 when its drive-low flag is set, otherwise 1'bz. The block never drives 1.
- PS2_CLK and PS2_DAT pass through 2-flop synchronizers. A falling edge is synced clock 1 -> 0 on consecutive samples; this adds 2-3 cycles of latency.
- Reset (async): state IDLE, both drive-low flags 0 (lines released), busy=0, cmd_sent=0, tx_error=0, bit counter=0, timers=0. Reset mid-frame releases the lines immediately; no error pulse.
- IDLE: if send_cmd=1, latch cmd_byte and odd parity (~^cmd_byte), set busy=1 next cycle, go INHIBIT.
- INHIBIT: drive PS2_CLK low for exactly INHIBIT_CYCLES cycles. In the last cycle, assert DAT drive-low (start bit). Go RTS.
- RTS: release CLK and keep DAT low. Wait for a falling edge of the device clock.
- SHIFT: bit counter 0..10. On each falling edge, set DAT drive for the next bit:
  - edges 1-8: data bits, LSB first; drive low iff bit=0
  - edge 9: parity bit
  - edge 10: release DAT (stop bit = 1)
  - edge 11: sample synced DAT as the ack bit, then go WAIT_IDLE.
- WAIT_IDLE: wait until synced CLK=1 and DAT=1, then go DONE.
- DONE: pulse cmd_sent for 1 cycle, busy=0, go IDLE. Back-to-back sends are allowed from the next cycle.
- Timeout: in RTS, SHIFT and WAIT_IDLE, the timer reloads on every falling edge. When it reaches TIMEOUT_CYCLES: release both lines, pulse tx_error, go IDLE with busy=0, no cmd_sent.
- send_cmd while busy=1 is ignored, not queued. Changes on cmd_byte after acceptance have no effect.
- cmd_sent and tx_error never assert in the same cycle.

Optional Feature:
Macro PS2_TX_ACK_CHECK_EN.
- Defined: if the ack sampled on edge 11 is 1 (device did not pull DAT low), go to ERROR. ERROR pulses tx_error, skips DONE, and still waits for lines idle or timeout before returning to IDLE.
- Undefined: the ack value is ignored and edge 11 always proceeds to WAIT_IDLE/DONE.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and acking -> PS2_CLK low for exactly 5000 cycles; bits sampled on device rising edges are start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1; cmd_sent pulses once; busy falls the same cycle.
- Send 0xF4 -> data bits 0,0,1,0,1,1,1,1, parity 0; cmd_sent=1 once; tx_error stays 0.
- Send 0xFF with the device model silent (no clocks) -> after RTS plus 750000 cycles, tx_error pulses, both lines return to Z, busy=0, cmd_sent never asserts.
- With PS2_TX_ACK_CHECK_EN defined, send 0x00 and the device leaves DAT high on edge 11 -> tx_error pulses, no cmd_sent. Repeat without the macro -> cmd_sent pulses.
- Assert send_cmd with 0x55 while busy sending 0xED -> the frame on the wire still carries 0xED and only one cmd_sent occurs. Then send 0x55 -> the next frame carries 0x55.
- Assert reset at edge 5 of a frame -> PS2_CLK and PS2_DAT go Z asynchronously, busy=0, no pulses. A following send of 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
// Host-to-device PS/2 command sender. It inhibits the bus, then requests to send.
// After that it shifts one command byte out on clocks generated by the device,
// and reports either completion or an error.
// Both PS/2 lines are open drain: the block only ever pulls a line low or releases it.
//
// Configuration macro:
//   PS2_TX_ACK_CHECK_EN - when defined, an ack bit left high by the device on the
//                         eleventh clock is reported as tx_error instead of cmd_sent.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    input  logic       send_cmd,
    input  logic [7:0] cmd_byte,
    output logic       busy,
    output logic       cmd_sent,
    output logic       tx_error
);

    // One timer serves both the inhibit interval and the device-clock watchdog.
    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic          INH_ONE  = (INHIBIT_CYCLES == 1) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    // The PS/2 parity bit makes the total number of ones in data plus parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t        state_q,    state_d;
    logic          clk_low_q,  clk_low_d;
    logic          dat_low_q,  dat_low_d;
    logic          busy_q,     busy_d;
    logic          cmd_sent_q, cmd_sent_d;
    logic          tx_error_q, tx_error_d;
    logic [3:0]    bit_cnt_q,  bit_cnt_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [7:0]    data_q,     data_d;
    logic          parity_q,   parity_d;

    logic          clk_s1_q,   clk_s1_d;
    logic          clk_s2_q,   clk_s2_d;
    logic          clk_prev_q, clk_prev_d;
    logic          dat_s1_q,   dat_s1_d;
    logic          dat_s2_q,   dat_s2_d;

    logic          clk_fall_s;
    logic          timed_out_s;

    // Open-drain pin drive: pull low or float, never drive high.
    assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

    assign busy     = busy_q;
    assign cmd_sent = cmd_sent_q;
    assign tx_error = tx_error_q;

    // A device clock edge is a high sample followed by a low sample on the synced line.
    assign clk_fall_s  = clk_prev_q & ~clk_s2_q;
    assign timed_out_s = (timer_q == TO_LAST);

    // Next state of the two-flop synchronizers and the edge-detect history.
    always_comb begin
        clk_s1_d   = PS2_CLK;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = PS2_DAT;
        dat_s2_d   = dat_s1_q;
    end

    // Synchronizer registers; an idle bus reads high, so they reset to 1.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
        end
    end

    // Transmit sequencer: next state, pin drive, counters and status pulses.
    always_comb begin
        state_d    = state_q;
        clk_low_d  = clk_low_q;
        dat_low_d  = dat_low_q;
        busy_d     = busy_q;
        cmd_sent_d = 1'b0;
        tx_error_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        data_d     = data_q;
        parity_d   = parity_q;

        case (state_q)
            ST_IDLE: begin
                if (send_cmd) begin
                    data_d    = cmd_byte;
                    parity_d  = odd_parity(cmd_byte);
                    busy_d    = 1'b1;
                    clk_low_d = 1'b1;
                    dat_low_d = INH_ONE;
                    timer_d   = '0;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_INHIBIT;
                end else begin
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b0;
                    busy_d    = 1'b0;
                end
            end

            ST_INHIBIT: begin
                // Hold CLK low. The start bit goes onto DAT in the last inhibit cycle.
                if (timer_q == INH_LAST) begin
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_RTS;
                end else begin
                    timer_d = timer_q + T_ONE;
                    if ((timer_q + T_ONE) == INH_LAST) begin
                        dat_low_d = 1'b1;
                    end else begin
                        dat_low_d = dat_low_q;
                    end
                end
            end

            ST_RTS: begin
                // The first device falling edge asks for data bit 0.
                if (clk_fall_s) begin
                    dat_low_d = ~data_q[0];
                    bit_cnt_d = 4'd1;
                    timer_d   = '0;
                    state_d   = ST_SHIFT;
                end else if (timed_out_s) begin
                    clk_low_d  = 1'b0;
                    dat_low_d  = 1'b0;
                    busy_d     = 1'b0;
                    tx_error_d = 1'b1;
                    bit_cnt_d  = 4'd0;
                    timer_d    = '0;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end

            ST_SHIFT: begin
                // bit_cnt_q is the number of falling edges already handled.
                if (clk_fall_s) begin
                    timer_d   = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    case (bit_cnt_q)
                        4'd8: begin
                            dat_low_d = ~parity_q;
                        end
                        4'd9: begin
                            dat_low_d = 1'b0;
                        end
                        4'd10: begin
                            dat_low_d = 1'b0;
                            bit_cnt_d = 4'd0;
`ifdef PS2_TX_ACK_CHECK_EN
                            if (dat_s2_q) begin
                                tx_error_d = 1'b1;
                                state_d    = ST_ERROR;
                            end else begin
                                state_d    = ST_WAIT_IDLE;
                            end
`else
                            state_d = ST_WAIT_IDLE;
`endif
                        end
                        default: begin
                            dat_low_d = ~data_q[bit_cnt_q[2:0]];
                        end
                    endcase
                end else if (timed_out_s) begin
                    clk_low_d  = 1'b0;
                    dat_low_d  = 1'b0;
                    busy_d     = 1'b0;
                    tx_error_d = 1'b1;
                    bit_cnt_d  = 4'd0;
                    timer_d    = '0;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end

            ST_WAIT_IDLE: begin
                // The frame is complete once the device releases both lines.
                if (clk_s2_q && dat_s2_q) begin
                    cmd_sent_d = 1'b1;
                    busy_d     = 1'b0;
                    timer_d    = '0;
                    state_d    = ST_DONE;
                end else if (clk_fall_s) begin
                    timer_d = '0;
                end else if (timed_out_s) begin
                    clk_low_d  = 1'b0;
                    dat_low_d  = 1'b0;
                    busy_d     = 1'b0;
                    tx_error_d = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            ST_ERROR: begin
                // The error pulse was already issued on entry. Wait here for an idle
                // bus, or for a timeout, without issuing a second pulse.
                if (clk_s2_q && dat_s2_q) begin
                    busy_d  = 1'b0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (clk_fall_s) begin
                    timer_d = '0;
                end else if (timed_out_s) begin
                    busy_d  = 1'b0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end

            default: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                busy_d    = 1'b0;
                bit_cnt_d = 4'd0;
                timer_d   = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers. Reset releases both lines at once and clears status.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clk_low_q  <= 1'b0;
            dat_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            cmd_sent_q <= 1'b0;
            tx_error_q <= 1'b0;
            bit_cnt_q  <= 4'd0;
            timer_q    <= '0;
            data_q     <= 8'h00;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_low_q  <= clk_low_d;
            dat_low_q  <= dat_low_d;
            busy_q     <= busy_d;
            cmd_sent_q <= cmd_sent_d;
            tx_error_q <= tx_error_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// tb_ps2_host_transmitter
// Directed and randomized sends against a PS/2 device model. The model clocks
// the frame, samples each bit on its rising clock edge, and optionally acks.
module tb_ps2_host_transmitter;

    localparam int INH  = 40;
    localparam int TOUT = 600;
    localparam int HALF = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       send_cmd;
    logic [7:0] cmd_byte;
    logic       busy;
    logic       cmd_sent;
    logic       tx_error;
    logic       dev_clk_low;
    logic       dev_dat_low;
    wire        ps2_clk;
    wire        ps2_dat;

    int errors      = 0;
    int checks      = 0;
    int sent_cnt    = 0;
    int err_cnt     = 0;
    int overlap_cnt = 0;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .send_cmd (send_cmd),
        .cmd_byte (cmd_byte),
        .busy     (busy),
        .cmd_sent (cmd_sent),
        .tx_error (tx_error)
    );

    always #10 clk = ~clk;

    // Pulse bookkeeping on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (cmd_sent) sent_cnt <= sent_cnt + 1;
        if (tx_error) err_cnt <= err_cnt + 1;
        if ((cmd_sent && tx_error) || ((cmd_sent || tx_error) && busy))
            overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        int v;
        v    = int'(b);
        ones = 0;
        f    = 11'd0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((v / (1 << i)) % 2) == 1;
            ones   = ones + (v / (1 << i)) % 2;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic bit expect_sent(input bit acked);
`ifdef PS2_TX_ACK_CHECK_EN
        return acked;
`else
        return 1'b1;
`endif
    endfunction

    task automatic start_send(input logic [7:0] b);
        @(negedge clk);
        send_cmd = 1'b1;
        cmd_byte = b;
        @(negedge clk);
        send_cmd = 1'b0;
        cmd_byte = ~b;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Device model. low_len counts the cycles CLK is held low by the host. bits[0]
    // is sampled when the host releases CLK; bits[e] on the rising edge after fall e.
    task automatic device_frame(input int n_edges, input bit do_ack, input bit poke,
                                output int low_len, output logic [10:0] bits);
        int budget;
        low_len = 0;
        bits    = 11'd0;
        budget  = 0;
        while (ps2_clk !== 1'b0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        while (ps2_clk === 1'b0 && low_len < 10 * INH) begin
            low_len++;
            @(negedge clk);
        end
        bits[0] = ps2_dat;
        for (int e = 1; e <= n_edges; e++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            if (poke && e == 3) begin
                send_cmd = 1'b1;
                cmd_byte = 8'h55;
            end
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (poke && e == 3) send_cmd = 1'b0;
            if (e <= 10) bits[e] = ps2_dat;
            if (e == 10 && do_ack) begin
                @(negedge clk);
                dev_dat_low = 1'b1;
            end
        end
        if (n_edges >= 11) begin
            repeat (2) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic finish_frame(input string tag, input int s0, input int e0, input bit exp_sent);
        int budget;
        budget = 0;
        while (sent_cnt == s0 && err_cnt == e0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_sent"}, 32'(sent_cnt - s0), 32'(exp_sent));
        chk({tag, "_err"}, 32'(err_cnt - e0), 32'(!exp_sent));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_lines_end"}, 32'({ps2_clk, ps2_dat}), 32'd3);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit do_ack, input bit poke);
        int s0;
        int e0;
        int low_len;
        logic [10:0] bits;
        s0 = sent_cnt;
        e0 = err_cnt;
        start_send(b);
        device_frame(11, do_ack, poke, low_len, bits);
        chk({tag, "_inhibit"}, 32'(low_len), 32'(INH));
        chk({tag, "_frame"}, 32'(bits), 32'(frame_of(b)));
        finish_frame(tag, s0, e0, expect_sent(do_ack));
    endtask

    initial begin
        int s0;
        int e0;
        int low_len;
        int delta;
        logic [10:0] bits;
        logic [7:0]  rb;

        reset       = 1'b1;
        send_cmd    = 1'b0;
        cmd_byte    = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pulses", 32'({cmd_sent, tx_error}), 32'd0);
        chk("reset_lines", 32'({ps2_clk, ps2_dat}), 32'd3);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED, with a 0x55 request arriving mid-frame that must be ignored.
        run_frame("ed", 8'hED, 1'b1, 1'b1);
        run_frame("b2b_55", 8'h55, 1'b1, 1'b0);
        run_frame("f4", 8'hF4, 1'b1, 1'b0);

        // Silent device: the watchdog fires TOUT cycles after CLK is released.
        s0 = sent_cnt;
        e0 = err_cnt;
        start_send(8'hFF);
        device_frame(0, 1'b0, 1'b0, low_len, bits);
        chk("silent_inhibit", 32'(low_len), 32'(INH));
        delta = 0;
        while (tx_error !== 1'b1 && delta < 2 * TOUT) begin
            @(negedge clk);
            delta++;
        end
        chk("timeout_latency", 32'(delta), 32'(TOUT));
        chk("timeout_lines", 32'({ps2_clk, ps2_dat}), 32'd3);
        chk("timeout_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("timeout_pulse_width", 32'(tx_error), 32'd0);
        chk("timeout_no_sent", 32'(sent_cnt - s0), 32'd0);
        repeat (5) @(negedge clk);

        // Device leaves DAT high on the ack clock.
        run_frame("noack_00", 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            run_frame($sformatf("rand%0d_%02h", i, rb), rb, 1'b1, 1'b0);
        end

        // Reset in the middle of a frame, after the fifth device edge.
        start_send(8'hED);
        device_frame(5, 1'b0, 1'b0, low_len, bits);
        chk("pre_reset_dat_low", 32'(ps2_dat), 32'd0);
        s0 = sent_cnt;
        e0 = err_cnt;
        #3;
        reset = 1'b1;
        #1;
        chk("reset_mid_lines", 32'({ps2_clk, ps2_dat}), 32'd3);
        chk("reset_mid_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_mid_no_pulses", 32'((sent_cnt - s0) + (err_cnt - e0)), 32'd0);
        run_frame("after_reset_f4", 8'hF4, 1'b1, 1'b0);

        chk("pulse_exclusive_busy_low", 32'(overlap_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
